// File: rtl/byte_striping_rx_pkg.sv
// Shared types and constants for the four-lane receive un-striper.
package byte_striping_rx_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int LANES      = 4;
  localparam logic [7:0] RESET_DATA = 8'h00;

  // State names the lane to be consumed on the next valid cycle.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LANE0 = 3'd1,
    LANE1 = 3'd2,
    LANE2 = 3'd3,
    LANE3 = 3'd4
  } lane_state_e;

endpackage

// File: rtl/byte_striping_rx_lane_mux4.sv
// Combinational 4:1 lane selector; zero latency; no flow control of its own.
module lane_mux4 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [1:0]            sel,
  input  logic [DATA_WIDTH-1:0] in0,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  input  logic [DATA_WIDTH-1:0] in3,
  output logic [DATA_WIDTH-1:0] dout
);

  always_comb begin
    dout = in0;
    case (sel)
      2'd0:    dout = in0;
      2'd1:    dout = in1;
      2'd2:    dout = in2;
      2'd3:    dout = in3;
      default: dout = in0;
    endcase
  end

endmodule

// File: rtl/byte_striping_rx.sv
// Re-serialises four lane bytes round-robin into one byte stream; 1-cycle registered latency.
// No backpressure: valid-only, a low valid freezes the lane pointer and outputs zero.
module byte_striping_rx #(
  parameter int DATA_WIDTH = byte_striping_rx_pkg::DATA_WIDTH,
  parameter int LANES      = byte_striping_rx_pkg::LANES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic [DATA_WIDTH-1:0] data_in3,
  output logic [DATA_WIDTH-1:0] data
);

  import byte_striping_rx_pkg::*;

  localparam int SEL_W = $clog2(LANES);

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [SEL_W-1:0]      sel;
  logic                  load;
  logic [DATA_WIDTH-1:0] lane_dat;

  lane_mux4 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mux (
    .sel  (sel),
    .in0  (data_in0),
    .in1  (data_in1),
    .in2  (data_in2),
    .in3  (data_in3),
    .dout (lane_dat)
  );

  // A low valid holds the pointer so a gap never skips or repeats a lane.
  always_comb begin
    state_nxt = state;
    sel       = SEL_W'(0);
    load      = 1'b0;
    case (state)
      IDLE, LANE0: begin
        sel = SEL_W'(0);
        if (valid) begin
          load      = 1'b1;
          state_nxt = LANE1;
        end
      end
      LANE1: begin
        sel = SEL_W'(1);
        if (valid) begin
          load      = 1'b1;
          state_nxt = LANE2;
        end
      end
      LANE2: begin
        sel = SEL_W'(2);
        if (valid) begin
          load      = 1'b1;
          state_nxt = LANE3;
        end
      end
      LANE3: begin
        sel = SEL_W'(3);
        if (valid) begin
          load      = 1'b1;
          state_nxt = LANE0;
        end
      end
      default: begin
        state_nxt = IDLE;
        load      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      data  <= DATA_WIDTH'(RESET_DATA);
    end else begin
      state <= state_nxt;
      data  <= load ? lane_dat : DATA_WIDTH'(RESET_DATA);
    end
  end

endmodule

// File: tb/tb_byte_striping_rx.sv
// Bench for byte_striping_rx: directed scenarios plus random stream against a lane-pointer model.
module tb_byte_striping_rx;

  logic       clk;
  logic       reset;
  logic       valid;
  logic [7:0] data_in0, data_in1, data_in2, data_in3;
  logic [7:0] data;

  int checks;
  int errors;

  // Reference model: next lane to take, and the byte expected after the last edge.
  int         mdl_ptr;
  logic [7:0] mdl_exp;

  byte_striping_rx #(.DATA_WIDTH(8), .LANES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .valid    (valid),
    .data_in0 (data_in0),
    .data_in1 (data_in1),
    .data_in2 (data_in2),
    .data_in3 (data_in3),
    .data     (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus, advance past the edge, and update the model.
  task automatic cycle(input logic v, input logic [7:0] l0, input logic [7:0] l1,
                       input logic [7:0] l2, input logic [7:0] l3);
    logic [7:0] lanes [4];
    valid = v; data_in0 = l0; data_in1 = l1; data_in2 = l2; data_in3 = l3;
    lanes[0] = l0; lanes[1] = l1; lanes[2] = l2; lanes[3] = l3;
    @(posedge clk);
    if (!reset) begin
      mdl_exp = 8'h00;
      mdl_ptr = 0;
    end else if (v) begin
      mdl_exp = lanes[mdl_ptr];
      mdl_ptr = (mdl_ptr + 1) % 4;
    end else begin
      mdl_exp = 8'h00;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cycle(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    cycle(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      checks++;
      if (data !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: got %h want 00", i, data);
      end
    end
    reset = 1'b1;
    cycle(1'b1, 8'h5A, 8'h11, 8'h22, 8'h33);
    checks++;
    if (data !== 8'h5A) begin
      errors++;
      $display("FAIL reset_first_lane0: got %h want 5a", data);
    end
    // Asynchronous assertion between edges must clear the output at once.
    cycle(1'b1, 8'h5A, 8'h77, 8'h22, 8'h33);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (data !== 8'h00) begin
      errors++;
      $display("FAIL reset_async: got %h want 00", data);
    end
    cycle(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    reset = 1'b1;
  endtask

  task automatic test_basic_group();
    logic [7:0] want [4];
    want[0] = 8'hA0; want[1] = 8'hA1; want[2] = 8'hA2; want[3] = 8'hA3;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
      checks++;
      if (data !== want[i]) begin
        errors++;
        $display("FAIL basic_group beat%0d: got %h want %h", i, data, want[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] want [8];
    do_reset();
    for (int i = 0; i < 8; i++) want[i] = (i < 4) ? 8'(8'h10 + i) : 8'(8'h20 + i - 4);
    for (int i = 0; i < 8; i++) begin
      if (i < 4) cycle(1'b1, 8'h10, 8'h11, 8'h12, 8'h13);
      else       cycle(1'b1, 8'h20, 8'h21, 8'h22, 8'h23);
      checks++;
      if (data !== want[i]) begin
        errors++;
        $display("FAIL wrap beat%0d: got %h want %h", i, data, want[i]);
      end
    end
  endtask

  task automatic test_gap();
    logic [7:0] want [7];
    logic       vseq [7];
    want[0] = 8'hB0; want[1] = 8'hB1; want[2] = 8'h00; want[3] = 8'h00;
    want[4] = 8'h00; want[5] = 8'hB2; want[6] = 8'hB3;
    vseq[0] = 1; vseq[1] = 1; vseq[2] = 0; vseq[3] = 0; vseq[4] = 0; vseq[5] = 1; vseq[6] = 1;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cycle(vseq[i], 8'hB0, 8'hB1, 8'hB2, 8'hB3);
      checks++;
      if (data !== want[i]) begin
        errors++;
        $display("FAIL gap beat%0d: got %h want %h", i, data, want[i]);
      end
    end
  endtask

  task automatic test_idle();
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 8'hC0, 8'hC1, 8'hC2, 8'hC3);
      if (data !== 8'h00) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_zero: got %0d nonzero cycles want 0", bad);
    end
    cycle(1'b1, 8'hC0, 8'hC1, 8'hC2, 8'hC3);
    checks++;
    if (data !== 8'hC0) begin
      errors++;
      $display("FAIL idle_then_lane0: got %h want c0", data);
    end
  endtask

  task automatic test_reset_mid_group();
    do_reset();
    cycle(1'b1, 8'hD0, 8'hD1, 8'hD2, 8'hD3);
    cycle(1'b1, 8'hD0, 8'hD1, 8'hD2, 8'hD3);
    reset = 1'b0;
    #1;
    checks++;
    if (data !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_clear: got %h want 00", data);
    end
    cycle(1'b1, 8'hD0, 8'hD1, 8'hD2, 8'hD3);
    reset = 1'b1;
    cycle(1'b1, 8'hE0, 8'hE1, 8'hE2, 8'hE3);
    checks++;
    if (data !== 8'hE0) begin
      errors++;
      $display("FAIL reset_mid_lane0: got %h want e0", data);
    end
    cycle(1'b1, 8'hE0, 8'hE1, 8'hE2, 8'hE3);
    checks++;
    if (data !== 8'hE1) begin
      errors++;
      $display("FAIL reset_mid_lane1: got %h want e1", data);
    end
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      checks++;
      if (data !== mdl_exp) begin
        errors++;
        bad++;
        if (bad <= 5) $display("FAIL random cyc%0d: got %h want %h", i, data, mdl_exp);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mdl_ptr = 0;
    mdl_exp = 8'h00;
    reset = 1'b0;
    valid = 1'b0;
    data_in0 = 8'h00; data_in1 = 8'h00; data_in2 = 8'h00; data_in3 = 8'h00;
    #2;
    checks++;
    if (data !== 8'h00) begin
      errors++;
      $display("FAIL reset_initial: got %h want 00", data);
    end
    test_reset();
    test_basic_group();
    test_wrap();
    test_gap();
    test_idle();
    test_reset_mid_group();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_striping_rx.md
# byte_striping_rx

Receive-side byte un-striper for the four-lane link. It takes four 8-bit lane inputs and re-serialises them into one 8-bit byte stream on a single clock, visiting lanes round-robin 0→1→2→3 while `valid` is high. It sits between the four per-lane receive paths and the byte-stream consumer. A small FSM tracks the lane pointer.

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of each lane and of the output byte
- `LANES`, 4, number of lanes (fixed; the FSM is written for 4)

Ports:
- `clk` input 1: single clock, rising-edge.
- `reset` input 1: asynchronous, active-low reset.
- `valid` input 1: lane data valid; high = consume one lane this cycle.
- `data_in0` input 8: lane 0 byte.
- `data_in1` input 8: lane 1 byte.
- `data_in2` input 8: lane 2 byte.
- `data_in3` input 8: lane 3 byte.
- `data` output 8: reassembled byte stream, registered.

## Operation
- FSM states: `IDLE`, `LANE0`, `LANE1`, `LANE2`, `LANE3`. The state names the lane to be consumed on the next valid cycle.
- Reset: state = `IDLE`, `data` = 8'h00.
- `IDLE`:
  - `valid`=1: `data` <= `data_in0`; next state `LANE1`.
  - `valid`=0: `data` <= 8'h00; stay in `IDLE`.
- `LANEk` (k=1..3):
  - `valid`=1: `data` <= `data_ink`; next state `LANE(k+1)`. From `LANE3` the next state is `LANE0`.
- `LANE0`:
  - `valid`=1: `data` <= `data_in0`; next state `LANE1`.
- Any `LANEk` with `valid`=0: `data` <= 8'h00; state holds. The stream resumes at the same lane, so a gap never skips or repeats a lane.
- Default/illegal state encoding: go to `IDLE` and drive `data` = 8'h00.
- Lanes are not buffered or deskewed. Lane inputs must be stable at the edge at which they are selected.

## Timing
- Latency: 1 cycle. A lane sampled at edge N appears on `data` after edge N until edge N+1.
- Throughput: one byte per clock while `valid`=1. A full 4-lane group takes 4 consecutive valid cycles.
- Reset assertion mid-stream clears `data` and returns to `IDLE` immediately (asynchronous). Release is synchronous to the next edge.
- First valid cycle after reset always takes lane 0.
- `valid` low on consecutive cycles: `data` stays 8'h00 and the pointer is frozen.

## Structure
- Shared package: state enum (`IDLE`, `LANE0`..`LANE3`, 3-bit encoding), `DATA_WIDTH`, `LANES`, reset value 8'h00.
- One sub-module is natural: `lane_mux4`, a combinational 4:1 8-bit mux selected by the 2-bit lane index. It is instantiated once; the FSM and output register stay in the top.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with random lane data -> `data`=8'h00, state `IDLE`; also assert `reset` mid-stream -> `data`=8'h00 immediately.
- Basic group: lanes = 8'hA0, 8'hA1, 8'hA2, 8'hA3, `valid`=1 for 4 cycles -> `data` = A0, A1, A2, A3 on the 4 cycles following each edge.
- Wrap-around: `valid`=1 for 8 cycles with lanes updated per group (10–13, then 20–23) -> `data` = 10, 11, 12, 13, 20, 21, 22, 23.
- Gap mid-group: `valid`=1 for 2 cycles, 0 for 3, then 1 for 2 with lanes B0–B3 -> `data` = B0, B1, 00, 00, 00, B2, B3.
- Idle: `valid`=0 for 10 cycles with nonzero lanes -> `data`=8'h00 throughout, and the next valid cycle outputs `data_in0`.
- Reset mid-group: reset pulse after lane 1 is consumed, then `valid`=1 -> the first post-reset byte is `data_in0`.
